// File: rtl/pixl_pkg.sv
// Shared types and constants for the UART pixel loader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: parser state enum, response byte codes, default frame sync byte,
// and a helper that tells which states pop the RX FIFO.
package pixl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GET_W     = 3'd1,
        GET_H     = 3'd2,
        PIXELS    = 3'd3,
        GET_CHK   = 3'd4,
        SEND_RESP = 3'd5
    } pixl_state_t;

    localparam logic [7:0] ACK               = 8'h06;
    localparam logic [7:0] NAK               = 8'h15;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Every state except SEND_RESP pulls bytes from the RX FIFO.
    function automatic logic is_consume_state(input pixl_state_t s);
        return (s == IDLE) || (s == GET_W) || (s == GET_H) ||
               (s == PIXELS) || (s == GET_CHK);
    endfunction

endpackage

// File: rtl/pixl_chk_acc.sv
// 8-bit clear/accumulate checksum register (modulo-256 sum of pixel bytes).
// Latency: sum reflects an accumulated byte one cycle after acc_en.
// Backpressure: none; accumulates only when acc_en is high.
//
// Ports: clk, reset (active-low sync), clr (zero the sum), acc_en (add din),
//        din[7:0] (byte to add), sum[7:0] (running checksum).
module pixl_chk_acc (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       acc_en,
    input  logic [7:0] din,
    output logic [7:0] sum
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            sum <= 8'd0;
        end else if (clr) begin
            sum <= 8'd0;
        end else if (acc_en) begin
            sum <= sum + din;   // wraps modulo 256
        end
    end

endmodule

// File: rtl/uart_pixel_loader.sv
// Parses framed image uploads from the UART RX FIFO into frame-buffer writes, replies ACK/NAK.
// Latency: pixel write 1 cycle after the byte is popped; response pushed the cycle after the last byte.
// Backpressure: pops only when RX FIFO non-empty; holds the response (no RX pops) while tx_full.
//
// Ports: clk, reset (active-low sync);
//        rx_empty/r_data/rd_uart   - show-ahead RX FIFO read side;
//        tx_full/wr_uart/w_data    - TX FIFO write side (w_data registered, holds last response);
//        pix_we/pix_addr/pix_data  - frame-buffer write port (row-major linear index);
//        frame_done (pulse with ACK), busy (not IDLE), err (sticky NAK flag).
// Build option: define PIXL_CHECKSUM_EN to expect and verify a trailing checksum byte;
//        without it, a frame ends after the last pixel and NAK is only for a zero dimension.
module uart_pixel_loader
    import pixl_pkg::*;
#(
    parameter int         ADDR_W    = 16,
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_empty,
    input  logic [7:0]        r_data,
    output logic              rd_uart,
    input  logic              tx_full,
    output logic              wr_uart,
    output logic [7:0]        w_data,
    output logic              pix_we,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [7:0]        pix_data,
    output logic              frame_done,
    output logic              busy,
    output logic              err
);

    pixl_state_t state_q;
    logic [7:0]  width_q;
    logic [7:0]  height_q;
    logic [15:0] cnt_q;
    logic        err_q;

    logic        consume;
    logic        send;
    logic        sync_hit;
    logic [15:0] total;
    logic        last_pix;

    // Popping is gated by reset so the FIFO is never drained while held in reset.
    assign consume  = reset && !rx_empty && is_consume_state(state_q);
    assign send     = reset && (state_q == SEND_RESP) && !tx_full;
    assign sync_hit = consume && (state_q == IDLE) && (r_data == SYNC_BYTE);

    assign total    = {8'd0, width_q} * {8'd0, height_q};
    assign last_pix = (cnt_q == total - 16'd1);

    assign rd_uart    = consume;
    assign wr_uart    = send;
    // w_data already carries the response while in SEND_RESP.
    assign frame_done = send && (w_data == ACK);
    // The sticky flag must read 1 in the very cycle the NAK goes out.
    assign err        = err_q || (send && (w_data == NAK));
    assign busy       = (state_q != IDLE);

`ifdef PIXL_CHECKSUM_EN
    logic [7:0] chk_sum;

    pixl_chk_acc u_chk_acc (
        .clk    (clk),
        .reset  (reset),
        .clr    (sync_hit),
        .acc_en (consume && (state_q == PIXELS)),
        .din    (r_data),
        .sum    (chk_sum)
    );
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            width_q  <= 8'd0;
            height_q <= 8'd0;
            cnt_q    <= 16'd0;
            err_q    <= 1'b0;
            w_data   <= 8'd0;
            pix_we   <= 1'b0;
            pix_addr <= '0;
            pix_data <= 8'd0;
        end else begin
            pix_we <= 1'b0;

            if (send && (w_data == NAK)) begin
                err_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    // Non-sync bytes are popped and dropped.
                    if (sync_hit) begin
                        err_q   <= 1'b0;
                        cnt_q   <= 16'd0;
                        state_q <= GET_W;
                    end
                end

                GET_W: begin
                    if (consume) begin
                        width_q <= r_data;
                        state_q <= GET_H;
                    end
                end

                GET_H: begin
                    if (consume) begin
                        height_q <= r_data;
                        if ((width_q == 8'd0) || (r_data == 8'd0)) begin
                            w_data  <= NAK;
                            state_q <= SEND_RESP;
                        end else begin
                            state_q <= PIXELS;
                        end
                    end
                end

                PIXELS: begin
                    if (consume) begin
                        pix_we   <= 1'b1;
                        pix_addr <= ADDR_W'(cnt_q);
                        pix_data <= r_data;
                        cnt_q    <= cnt_q + 16'd1;
                        if (last_pix) begin
`ifdef PIXL_CHECKSUM_EN
                            state_q <= GET_CHK;
`else
                            w_data  <= ACK;
                            state_q <= SEND_RESP;
`endif
                        end
                    end
                end

                GET_CHK: begin
`ifdef PIXL_CHECKSUM_EN
                    if (consume) begin
                        w_data  <= (r_data == chk_sum) ? ACK : NAK;
                        state_q <= SEND_RESP;
                    end
`else
                    state_q <= IDLE;
`endif
                end

                SEND_RESP: begin
                    if (!tx_full) begin
                        state_q <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_pixel_loader.sv
// Self-checking bench for uart_pixel_loader: queue-based RX FIFO model,
// frame-level reference (expected pixels, response, timing) and scoreboard.
module tb_uart_pixel_loader;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam logic [7:0] ACKB = 8'h06;
    localparam logic [7:0] NAKB = 8'h15;
`ifdef PIXL_CHECKSUM_EN
    localparam int CHK_EN = 1;
`else
    localparam int CHK_EN = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_empty;
    logic [7:0]  r_data;
    logic        rd_uart;
    logic        tx_full;
    logic        wr_uart;
    logic [7:0]  w_data;
    logic        pix_we;
    logic [15:0] pix_addr;
    logic [7:0]  pix_data;
    logic        frame_done;
    logic        busy;
    logic        err;

    uart_pixel_loader #(.ADDR_W(16), .SYNC_BYTE(8'hA5)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_empty   (rx_empty),
        .r_data     (r_data),
        .rd_uart    (rd_uart),
        .tx_full    (tx_full),
        .wr_uart    (wr_uart),
        .w_data     (w_data),
        .pix_we     (pix_we),
        .pix_addr   (pix_addr),
        .pix_data   (pix_data),
        .frame_done (frame_done),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Stimulus and recorded DUT activity
    logic [7:0] rxq[$];
    int         gap_pct = 0;
    bit         txf = 1'b0;
    int         cyc = 0;
    bit         rd_s, wr_s;
    bit         viol;
    bit         timeout_hit;
    int         pop_c[$];
    bit         busy_at_pop[$];
    int         wr_a[$], wr_d[$], wr_c[$];
    logic [7:0] rsp_b[$];
    int         rsp_c[$];
    bit         rsp_fd[$], rsp_err[$];

    // Reference expectations for the frame under test
    logic [7:0] exp_pix[$];
    logic [7:0] exp_resp;
    int         exp_dur;
    int         sync_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic tick();
        cyc++;
        rx_empty = (rxq.size() == 0) || ($urandom_range(0, 99) < gap_pct);
        r_data   = (rxq.size() != 0) ? rxq[0] : 8'h00;
        tx_full  = txf;
        #1;
        rd_s = rd_uart;
        wr_s = wr_uart;
        if (rd_uart && rx_empty) viol = 1'b1;
        if (frame_done && !wr_uart) viol = 1'b1;
        if (rd_uart) begin
            pop_c.push_back(cyc);
            busy_at_pop.push_back(busy);
            void'(rxq.pop_front());
        end
        if (wr_uart) begin
            rsp_b.push_back(w_data);
            rsp_c.push_back(cyc);
            rsp_fd.push_back(frame_done);
            rsp_err.push_back(err);
        end
        @(negedge clk);
        if (pix_we) begin
            wr_a.push_back(int'(pix_addr));
            wr_d.push_back(int'(pix_data));
            wr_c.push_back(cyc + 1);
        end
    endtask

    task automatic clear_rec();
        pop_c.delete(); busy_at_pop.delete();
        wr_a.delete(); wr_d.delete(); wr_c.delete();
        rsp_b.delete(); rsp_c.delete(); rsp_fd.delete(); rsp_err.delete();
        viol = 1'b0;
        timeout_hit = 1'b0;
    endtask

    // Appends a frame to the RX stream and computes what the block must do with it.
    // fixed=1 uses pixels 0A,14,1E,28 (2x2 reference frame).
    task automatic push_frame(input int w, input int h, input bit bad, input bit fixed);
        logic [7:0] p, sum;
        logic [7:0] fixed_pix[4];
        int n;
        fixed_pix = '{8'h0A, 8'h14, 8'h1E, 8'h28};
        sync_idx = rxq.size();
        exp_pix.delete();
        sum = 8'd0;
        n = w * h;
        rxq.push_back(SYNC);
        rxq.push_back(8'(w));
        rxq.push_back(8'(h));
        if (n == 0) begin
            exp_resp = NAKB;
            exp_dur  = 4;
        end else begin
            for (int i = 0; i < n; i++) begin
                p = fixed ? fixed_pix[i % 4] : 8'($urandom_range(0, 255));
                rxq.push_back(p);
                exp_pix.push_back(p);
                sum = sum + p;
            end
            if (CHK_EN != 0) begin
                rxq.push_back(bad ? sum + 8'd1 : sum);
                exp_resp = bad ? NAKB : ACKB;
            end else begin
                exp_resp = ACKB;
            end
            exp_dur = 3 + n + CHK_EN + 1;
        end
    endtask

    task automatic run_until_resp(input int budget);
        int k = 0;
        while (!(rsp_b.size() > 0 && rxq.size() == 0) && k < budget) begin
            tick();
            k++;
        end
        timeout_hit = !(rsp_b.size() > 0 && rxq.size() == 0);
        repeat (2) tick();
    endtask

    task automatic check_frame(input string tag, input bit timed);
        int n;
        bit bb;
        chk({tag, " timeout"}, 32'(timeout_hit), 0);
        chk({tag, " resp_count"}, rsp_b.size(), 1);
        chk({tag, " resp_byte"}, rsp_b.size() > 0 ? 32'(rsp_b[0]) : 32'hDEAD, 32'(exp_resp));
        chk({tag, " frame_done"}, rsp_fd.size() > 0 ? 32'(rsp_fd[0]) : 32'hDEAD, 32'(exp_resp == ACKB));
        chk({tag, " err_at_send"}, rsp_err.size() > 0 ? 32'(rsp_err[0]) : 32'hDEAD, 32'(exp_resp == NAKB));
        chk({tag, " write_count"}, wr_a.size(), exp_pix.size());
        n = (wr_a.size() < exp_pix.size()) ? wr_a.size() : exp_pix.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s addr[%0d]", tag, i), wr_a[i], i);
            chk($sformatf("%s data[%0d]", tag, i), wr_d[i], 32'(exp_pix[i]));
            if (sync_idx + 3 + i < pop_c.size())
                chk($sformatf("%s latency[%0d]", tag, i), wr_c[i], pop_c[sync_idx + 3 + i] + 1);
        end
        if (timed && rsp_c.size() > 0 && pop_c.size() > sync_idx)
            chk({tag, " frame_cycles"}, rsp_c[0] - pop_c[sync_idx] + 1, exp_dur);
        bb = 1'b0;
        for (int i = 0; i <= sync_idx && i < busy_at_pop.size(); i++) bb |= busy_at_pop[i];
        chk({tag, " busy_before_sync"}, 32'(bb), 0);
        if (busy_at_pop.size() > sync_idx + 1)
            chk({tag, " busy_after_sync"}, 32'(busy_at_pop[sync_idx + 1]), 1);
        chk({tag, " protocol"}, 32'(viol), 0);
        chk({tag, " busy_end"}, 32'(busy), 0);
        chk({tag, " err_end"}, 32'(err), 32'(exp_resp == NAKB));
        chk({tag, " w_data_hold"}, 32'(w_data), 32'(exp_resp));
        chk({tag, " rx_drained"}, rxq.size(), 0);
    endtask

    initial begin
        int k;
        bit held_bad;

        reset = 1'b0; rx_empty = 1'b1; r_data = 8'h00; tx_full = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset ctrl", {26'd0, rd_uart, wr_uart, pix_we, frame_done, busy, err}, 0);
        chk("reset w_data", 32'(w_data), 0);
        chk("reset pix_addr", 32'(pix_addr), 0);
        chk("reset pix_data", 32'(pix_data), 0);
        reset = 1'b1;

        // Reference 2x2 frame
        clear_rec();
        push_frame(2, 2, 1'b0, 1'b1);
        run_until_resp(100);
        check_frame("frameA", 1'b1);

`ifdef PIXL_CHECKSUM_EN
        // Bad checksum: writes still happen, NAK, sticky err; next good frame clears it
        clear_rec();
        push_frame(2, 2, 1'b1, 1'b1);
        run_until_resp(100);
        check_frame("bad_chk", 1'b1);
        clear_rec();
        push_frame(3, 2, 1'b0, 1'b0);
        run_until_resp(100);
        check_frame("after_bad", 1'b1);
`endif

        // Noise before sync
        clear_rec();
        rxq.push_back(8'h00); rxq.push_back(8'hFF); rxq.push_back(8'h13);
        push_frame(3, 2, 1'b0, 1'b0);
        run_until_resp(100);
        check_frame("noise", 1'b1);

        // Zero dimensions
        clear_rec();
        push_frame(0, 5, 1'b0, 1'b0);
        run_until_resp(50);
        check_frame("zero_w", 1'b1);
        clear_rec();
        push_frame(3, 0, 1'b0, 1'b0);
        run_until_resp(50);
        check_frame("zero_h", 1'b1);

        // TX full held for 10 cycles in SEND_RESP, with extra bytes waiting in RX
        clear_rec();
        push_frame(2, 1, 1'b0, 1'b0);
        rxq.push_back(8'h11); rxq.push_back(8'h22);
        txf = 1'b1;
        k = 0;
        while (rxq.size() > 2 && k < 50) begin tick(); k++; end
        chk("hold reached", rxq.size(), 2);
        held_bad = 1'b0;
        repeat (10) begin
            tick();
            if (rd_s || wr_s) held_bad = 1'b1;
        end
        chk("hold quiet", 32'(held_bad), 0);
        txf = 1'b0;
        tick();
        chk("hold wr_first", 32'(wr_s), 1);
        repeat (4) tick();
        check_frame("hold", 1'b0);

        // Reset after 2 of 4 pixels, then a full frame from address 0
        clear_rec();
        push_frame(2, 2, 1'b0, 1'b1);
        k = 0;
        while (wr_a.size() < 2 && k < 50) begin tick(); k++; end
        chk("mid_reset writes_before", wr_a.size(), 2);
        reset = 1'b0; rx_empty = 1'b1;
        @(negedge clk);
        chk("mid_reset ctrl", {26'd0, rd_uart, wr_uart, pix_we, frame_done, busy, err}, 0);
        chk("mid_reset w_data", 32'(w_data), 0);
        chk("mid_reset pix_addr", 32'(pix_addr), 0);
        chk("mid_reset pix_data", 32'(pix_data), 0);
        reset = 1'b1;
        clear_rec();
        push_frame(2, 2, 1'b0, 1'b1);
        run_until_resp(100);
        check_frame("after_reset", 1'b1);

        // Randomised frames, some with RX gaps
        for (int f = 0; f < 6; f++) begin
            int w, h;
            clear_rec();
            gap_pct = (f % 2 == 1) ? 30 : 0;
            w = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
            h = $urandom_range(1, 6);
            push_frame(w, h, 1'(($urandom_range(0, 3) == 0) ? 1 : 0), 1'b0);
            run_until_resp(600);
            check_frame($sformatf("rand%0d", f), gap_pct == 0);
        end
        gap_pct = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_pixel_loader.md
# uart_pixel_loader

Consumes the byte stream from the UART receive FIFO and parses framed image uploads: sync byte, width, height, pixel bytes, and an optional checksum. Each pixel is written to a frame-buffer RAM port at a linear address. The block then returns a one-byte ACK or NAK through the UART transmit FIFO. It sits directly downstream of the UART's `r_data`/`rd_uart`/`rx_empty` port and shares its `w_data`/`wr_uart`/`tx_full` port.

## Interface
- `ADDR_W`, 16: frame-buffer address width; must be ≥16 to hold 255×255−1.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `clk` in 1: system clock.
- `reset` in 1: active-low synchronous reset; one clock domain.
- `rx_empty` in 1: RX FIFO empty.
- `r_data` in 8: RX FIFO head byte (show-ahead, valid while `rx_empty`=0).
- `rd_uart` out 1: pop RX FIFO this cycle.
- `tx_full` in 1: TX FIFO full.
- `wr_uart` out 1: push `w_data` into TX FIFO this cycle.
- `w_data` out 8: response byte.
- `pix_we` out 1: frame-buffer write strobe.
- `pix_addr` out ADDR_W: pixel index, row-major, 0-based.
- `pix_data` out 8: pixel value.
- `frame_done` out 1: one-cycle pulse when ACK is sent.
- `busy` out 1: high when the state is not IDLE.
- `err` out 1: sticky NAK flag.

## Operation
- Frame format: `SYNC_BYTE`, W, H, W×H pixel bytes, then CHK. CHK is the 8-bit modulo-256 sum of the pixel bytes.
- Byte consume rule: `rd_uart` = ~`rx_empty` AND state ∈ {IDLE, GET_W, GET_H, PIXELS, GET_CHK}. It is combinational, and at most one byte is consumed per cycle. `r_data` is sampled in the same cycle.
- State machine transitions:
  - IDLE: a byte equal to `SYNC_BYTE` goes to GET_W and clears `err`, the pixel counter and the checksum. Any other byte is discarded.
  - GET_W: latch W, go to GET_H.
  - GET_H: latch H. If W=0 or H=0, go to SEND_RESP with NAK. Otherwise compute total = W×H (16 bits, unsigned) and go to PIXELS.
  - PIXELS: on each consumed byte, add it to the checksum (8 bits, wraps) and increment the counter. After byte number total−1 is consumed, go to GET_CHK.
  - GET_CHK: response is ACK (8'h06) if the received byte equals the checksum, else NAK (8'h15). Go to SEND_RESP.
  - SEND_RESP: while `tx_full`=1, wait and consume no RX bytes. When `tx_full`=0, assert `wr_uart` for one cycle with `w_data` = response, then go to IDLE.
- Pixel writes are already committed when a NAK is sent. There is no rollback.
- A `SYNC_BYTE` value inside the pixel or checksum phases is treated as data. There is no resynchronisation mid-frame.
- `err` goes to 1 in the cycle `wr_uart` sends NAK. It holds until the next sync byte is accepted.

## Timing
- Reset (`reset`=0 at a `clk` edge): state goes to IDLE. Counter, checksum, W and H clear. All outputs are 0: `rd_uart`, `wr_uart`, `w_data`, `pix_we`, `pix_addr`, `pix_data`, `frame_done`, `busy`, `err`.
- Reset mid-frame abandons the frame. Bytes still in the RX FIFO are discarded in IDLE until a sync byte arrives.
- Pixel write latency: 1 cycle. A pixel consumed in cycle n gives `pix_we`=1 in cycle n+1, with registered `pix_addr` = index and `pix_data` = byte. `pix_we` is 0 in all other cycles.
- Back-to-back pixel bytes produce back-to-back writes.
- `frame_done` is high in the same cycle as `wr_uart` carrying ACK.
- `w_data` is registered and holds the last response value.
- Minimum frame time: 3 + W×H + 1 + 1 cycles when the RX FIFO is never empty and `tx_full`=0.

## Configuration
- Macro: `PIXL_CHECKSUM_EN`.
- Defined: GET_CHK state is present and behaves as above.
- Undefined:
  - There is no CHK byte and no checksum accumulator.
  - After the last pixel, go directly to SEND_RESP with ACK.
  - NAK is sent only for a zero dimension.

## Structure
- Shared package `pixl_pkg` holds:
  - the state enum (IDLE, GET_W, GET_H, PIXELS, GET_CHK, SEND_RESP);
  - the constants ACK=8'h06, NAK=8'h15 and the default SYNC_BYTE.
- One sub-module, `pixl_chk_acc`: the 8-bit clear/accumulate checksum register. It is instantiated only under `PIXL_CHECKSUM_EN`.
- The FSM, counter and write-port registers live in the top module.

## Test plan
- Frame A5,02,02,0A,14,1E,28,64 → writes at addr 0..3 with data 0A,14,1E,28; `w_data`=06; `frame_done` pulses once; `err`=0.
- Same frame with CHK=65 → four writes still occur; `w_data`=15; `err`=1. A following good frame clears `err`.
- Noise 00,FF,13 before the sync byte → all popped, no writes, `busy` stays 0 until A5 is consumed.
- Header A5,00,05 → no writes; NAK sent immediately; state returns to IDLE.
- Hold `tx_full`=1 for 10 cycles at SEND_RESP → `wr_uart` stays 0 and `rd_uart` stays 0; `wr_uart` fires in the first cycle after `tx_full` drops.
- `reset`=0 after 2 of 4 pixels → all outputs 0. The next full frame writes from addr 0 and is ACKed.
